// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART receiver: parity-mode encodings,
// receiver FSM states and the parity-check rule.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

  // xor_all is the XOR of every data bit together with the received parity bit.
  function automatic logic parity_error(input logic xor_all, input int mode);
    case (mode)
      PARITY_ODD:  return xor_all != 1'b1;
      PARITY_EVEN: return xor_all != 1'b0;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers. A push into a full FIFO
// succeeds only when a pop happens in the same cycle; otherwise it is dropped.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] free_o,
  output logic                   drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full || do_pop);
    drop_o   = push_i && full && !do_pop;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    free_o   = DEPTH_W - (wr_ptr_q - rd_ptr_q);
    rdata_o  = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: nothing is read out until a pointer says it was written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_framed.sv
// UART receiver with configurable framing, parity and stop bits, feeding a
// small receive FIFO with RTS flow control and an overrun pulse.
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 54,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 uart_rx,
  output logic                 uart_rts,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  output rx_state_e            dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int EW = DATA_BITS + 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  rx_state_e            state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic [1:0]           settle_q;
  logic                 armed_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 overrun_q;
  logic                 rts_q;
  logic                 rx_s;
  logic                 tick;
  logic                 push;
  logic [EW-1:0]        push_data;
  logic [EW-1:0]        fifo_rdata;
  logic                 fifo_empty;
  logic [AW:0]          fifo_free;
  logic                 fifo_drop;

  assign rx_s = sync2_q;

  // A start is only accepted once the synchronizer holds real line samples
  // and the line has been seen high, so a line held low through reset is ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      settle_q  <= '0;
      armed_q   <= 1'b0;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      overrun_q <= 1'b0;
      rts_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      sync1_q   <= uart_rx;
      sync2_q   <= sync1_q;
      settle_q  <= {settle_q[0], 1'b1};
      armed_q   <= armed_q | (settle_q[1] & sync2_q);
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      overrun_q <= fifo_drop;
      rts_q     <= |fifo_free[AW:1];
    end
  end

  assign tick = (state_q == ST_START) ? (cnt_q == HALF_M1) : (cnt_q == FULL_M1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (armed_q && !rx_s) state_d = ST_START;
      ST_START:     if (tick) state_d = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:      if (tick && bit_q == LAST_DATA)
                      state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY:    if (tick) state_d = ST_STOP;
      ST_STOP:      if (tick && bit_q == LAST_STOP) state_d = rx_s ? ST_IDLE : ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (rx_s) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    ferr_d    = ferr_q;
    perr_d    = perr_q;
    push      = 1'b0;
    push_data = {perr_q, ferr_q | ~rx_s, shift_q};
    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        ferr_d = 1'b0;
        perr_d = 1'b0;
      end
      ST_START: if (tick) begin
        cnt_d = '0;
        bit_d = '0;
      end
      ST_DATA: if (tick) begin
        cnt_d   = '0;
        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
        bit_d   = (bit_q == LAST_DATA) ? 4'd0 : bit_q + 4'd1;
      end
      ST_PARITY: if (tick) begin
        cnt_d  = '0;
        perr_d = parity_error(^shift_q ^ rx_s, PARITY);
      end
      ST_STOP: if (tick) begin
        cnt_d = '0;
        bit_d = bit_q + 4'd1;
        if (!rx_s) ferr_d = 1'b1;
        if (bit_q == LAST_STOP) push = 1'b1;
      end
      default: cnt_d = '0;
    endcase
  end

  // Consumer handshake: the head entry transfers on any cycle where rx_valid and
  // rx_ready are both high; rx_ready alone does nothing and rx_valid never waits on it.
  sync_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clock),
    .rst_i  (reset),
    .push_i (push),
    .wdata_i(push_data),
    .pop_i  (rx_ready),
    .rdata_o(fifo_rdata),
    .empty_o(fifo_empty),
    .free_o (fifo_free),
    .drop_o (fifo_drop)
  );

  always_comb begin
    rx_valid = !fifo_empty;
    {rx_parity_err, rx_frame_err, rx_data} = rx_valid ? fifo_rdata : '0;
    uart_rts  = rts_q;
    overrun   = overrun_q;
    dbg_state = state_q;
  end

endmodule
